// File: rtl/multi_block_trig_handler_pkg.sv
// Shared definitions for the multi-block soft-trigger readout handler:
// FSM state encoding, a ceil-log2 helper and the block-count clamp.
package multi_block_trig_handler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HIST_REQ = 3'd1,
        ST_LOCK     = 3'd2,
        ST_READ     = 3'd3,
        ST_UNLOCK   = 3'd4,
        ST_FREE     = 3'd5,
        ST_NEXT_ID  = 3'd6
    } state_e;

    localparam int NB_BITS = 5;

    function automatic int clogb2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Zero blocks means one block; anything above the build limit is capped.
    function automatic logic [NB_BITS-1:0] clamp_nblocks(input logic [NB_BITS-1:0] n,
                                                         input logic [NB_BITS-1:0] max_b);
        if (n == '0) begin
            return NB_BITS'(1);
        end
        if (n > max_b) begin
            return max_b;
        end
        return n;
    endfunction

endpackage

// File: rtl/multi_block_trig_handler_block_step_seq.sv
// Walks idx = 0..nb-1 from a base block: one strobe per step, waits for the
// step's ack, and flags the final step so the caller can change phase.
module block_step_seq
    import multi_block_trig_handler_pkg::*;
#(
    parameter int BLOCK_BITS = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [BLOCK_BITS-1:0] base_i,
    input  logic                  run_i,
    input  logic                  ack_i,
    input  logic [NB_BITS-1:0]    nb_i,
    output logic                  strobe_o,
    output logic [BLOCK_BITS-1:0] addr_o,
    output logic                  last_o,
    output logic                  done_o
);

    logic [BLOCK_BITS-1:0] base_q, base_d;
    logic [NB_BITS-1:0]    idx_q, idx_d;
    logic                  issued_q, issued_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            base_q   <= '0;
            idx_q    <= '0;
            issued_q <= 1'b0;
        end else begin
            base_q   <= base_d;
            idx_q    <= idx_d;
            issued_q <= issued_d;
        end
    end

    // Address wraps modulo 2^BLOCK_BITS by plain truncation of the sum.
    assign addr_o   = base_q + BLOCK_BITS'(idx_q);
    assign last_o   = (idx_q == nb_i - NB_BITS'(1));
    assign strobe_o = run_i && !issued_q;
    assign done_o   = run_i && ack_i && last_o;

    always_comb begin
        base_d   = base_q;
        idx_d    = idx_q;
        issued_d = issued_q;
        if (start_i) begin
            base_d   = base_i;
            idx_d    = '0;
            issued_d = 1'b0;
        end else if (run_i && ack_i) begin
            // Clearing issued re-strobes the next step (or the next phase) at once.
            issued_d = 1'b0;
            idx_d    = last_o ? '0 : idx_q + NB_BITS'(1);
        end else if (run_i) begin
            issued_d = 1'b1;
        end
    end

endmodule

// File: rtl/multi_block_trig_handler.sv
// Soft-trigger readout handler: history request, then lock/read/unlock/free
// over N consecutive blocks, then bump the event ID. One trigger may queue.
module multi_block_trig_handler
    import multi_block_trig_handler_pkg::*;
#(
    parameter int BLOCK_BITS = 9,
    parameter int MAX_BLOCKS = 4,
    parameter int ID_BITS    = 32,
    parameter int DROP_BITS  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  soft_trig_i,
    input  logic [BLOCK_BITS-1:0] nprev_i,
    input  logic [4:0]            nblocks_i,
    output logic                  history_req_o,
    input  logic                  history_ack_i,
    output logic [BLOCK_BITS-1:0] nprev_o,
    input  logic [BLOCK_BITS-1:0] block_i,
    output logic [BLOCK_BITS-1:0] lock_address_o,
    output logic                  lock_strobe_o,
    output logic                  lock_o,
    input  logic                  lock_ack_i,
    output logic [BLOCK_BITS-1:0] read_address_o,
    output logic                  read_last_o,
    output logic                  read_strobe_o,
    input  logic                  read_done_i,
    output logic [ID_BITS-1:0]    event_id_o,
    output logic [BLOCK_BITS-1:0] free_address_o,
    output logic                  free_strobe_o,
    input  logic                  free_ack_i,
    output logic                  busy_o,
    output logic [DROP_BITS-1:0]  drop_count_o
);

    localparam logic [NB_BITS-1:0] MAX_NB = NB_BITS'(MAX_BLOCKS);

    state_e                state_q, state_d;
    logic                  pending_q, pending_d;
    logic [DROP_BITS-1:0]  drop_q, drop_d;
    logic [ID_BITS-1:0]    event_id_q, event_id_d;
    logic [BLOCK_BITS-1:0] nprev_q, nprev_d;
    logic [NB_BITS-1:0]    nb_q, nb_d;

    logic                  seq_start, seq_run, seq_ack;
    logic                  seq_strobe, seq_last, seq_done;
    logic [BLOCK_BITS-1:0] seq_addr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b0;
            drop_q     <= '0;
            event_id_q <= '0;
            nprev_q    <= '0;
            nb_q       <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
            event_id_q <= event_id_d;
            nprev_q    <= nprev_d;
            nb_q       <= nb_d;
        end
    end

    assign seq_start = (state_q == ST_HIST_REQ) && history_ack_i;
    assign seq_run   = (state_q == ST_LOCK) || (state_q == ST_READ) ||
                       (state_q == ST_UNLOCK) || (state_q == ST_FREE);

    // Only the ack belonging to the current phase reaches the step sequencer.
    always_comb begin
        seq_ack = 1'b0;
        case (state_q)
            ST_LOCK, ST_UNLOCK: seq_ack = lock_ack_i;
            ST_READ:            seq_ack = read_done_i;
            ST_FREE:            seq_ack = free_ack_i;
            default:            seq_ack = 1'b0;
        endcase
    end

    block_step_seq #(
        .BLOCK_BITS (BLOCK_BITS)
    ) u_step (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (seq_start),
        .base_i   (block_i),
        .run_i    (seq_run),
        .ack_i    (seq_ack),
        .nb_i     (nb_q),
        .strobe_o (seq_strobe),
        .addr_o   (seq_addr),
        .last_o   (seq_last),
        .done_o   (seq_done)
    );

    assign history_req_o  = (state_q == ST_HIST_REQ) && !history_ack_i;
    assign nprev_o        = nprev_q;
    assign lock_address_o = seq_addr;
    assign read_address_o = seq_addr;
    assign free_address_o = seq_addr;
    assign lock_strobe_o  = seq_strobe && ((state_q == ST_LOCK) || (state_q == ST_UNLOCK));
    assign lock_o         = (state_q == ST_LOCK);
    assign read_strobe_o  = seq_strobe && (state_q == ST_READ);
    assign read_last_o    = seq_last;
    assign free_strobe_o  = seq_strobe && (state_q == ST_FREE);
    assign event_id_o     = event_id_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign drop_count_o   = drop_q;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        drop_d     = drop_q;
        event_id_d = event_id_q;
        nprev_d    = nprev_q;
        nb_d       = nb_q;

        // A trigger while busy queues once; further ones are counted as lost.
        if (soft_trig_i && (state_q != ST_IDLE)) begin
            if (!pending_q && (state_q != ST_NEXT_ID)) begin
                pending_d = 1'b1;
            end else if (pending_q && (drop_q != '1)) begin
                drop_d = drop_q + DROP_BITS'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (soft_trig_i) begin
                    nprev_d = nprev_i;
                    nb_d    = clamp_nblocks(nblocks_i, MAX_NB);
                    state_d = ST_HIST_REQ;
                end
            end
            ST_HIST_REQ: if (history_ack_i) state_d = ST_LOCK;
            ST_LOCK:     if (seq_done) state_d = ST_READ;
            ST_READ:     if (seq_done) state_d = ST_UNLOCK;
            ST_UNLOCK:   if (seq_done) state_d = ST_FREE;
            ST_FREE:     if (seq_done) state_d = ST_NEXT_ID;
            ST_NEXT_ID: begin
                event_id_d = event_id_q + ID_BITS'(1);
                // A fresh trigger in this cycle becomes the queued one and is served directly.
                if (pending_q || soft_trig_i) begin
                    pending_d = 1'b0;
                    nprev_d   = nprev_i;
                    nb_d      = clamp_nblocks(nblocks_i, MAX_NB);
                    state_d   = ST_HIST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
